// File: rtl/screen_write_sequencer_pkg.sv
// Shared terminal definitions: screen geometry, fill character and command opcodes.
package term_pkg;
  localparam int COLS   = 64;
  localparam int ROWS   = 16;
  localparam int ADDR_W = 10;
  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] COL_MASK  = ADDR_W'(COLS-1);

  typedef enum logic [1:0] {
    OP_PUTC       = 2'd0,
    OP_CLR_SCREEN = 2'd1,
    OP_CLR_EOL    = 2'd2,
    OP_SCROLL     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_PUTC, S_CLEAR, S_COPY, S_FILL
  } state_e;
endpackage

// File: rtl/screen_write_sequencer_if.sv
// Command handshake from the front end plus the char buffer write/read port.
interface screen_write_sequencer_if;
  import term_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  op_e               cmd_op;
  logic [7:0]        cmd_char;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic              buf_wen;
  logic [ADDR_W-1:0] buf_raddr;
  // Data for buf_raddr, sampled by the sequencer on the edge closing the cycle raddr is shown.
  logic [7:0]        buf_rdata;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_char, cmd_addr, buf_rdata,
    output cmd_ready, buf_waddr, buf_wdata, buf_wen, buf_raddr, busy, done
  );
  modport master (
    output cmd_valid, cmd_op, cmd_char, cmd_addr, buf_rdata,
    input  cmd_ready, buf_waddr, buf_wdata, buf_wen, buf_raddr, busy, done
  );
endinterface

// File: rtl/screen_write_sequencer.sv
// Sole writer of the char buffer: turns put/clear/scroll commands into one write per cycle.
module screen_write_sequencer
  import term_pkg::*;
(
  input logic                    clk,
  input logic                    clr,
  screen_write_sequencer_if.slave bus
);
  state_e            state;
  logic [ADDR_W-1:0] end_addr;
  logic [ADDR_W-1:0] waddr_nxt;

  assign waddr_nxt = bus.buf_waddr + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state         <= S_IDLE;
      end_addr      <= '0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.buf_wen   <= 1'b0;
      bus.done      <= 1'b0;
      bus.buf_waddr <= '0;
      bus.buf_raddr <= '0;
      bus.buf_wdata <= '0;
    end else begin
      bus.buf_wen <= 1'b0;
      bus.done    <= 1'b0;
      case (state)
        S_IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
          bus.cmd_ready <= 1'b0;
          bus.busy      <= 1'b1;
          case (bus.cmd_op)
            OP_PUTC: begin
              bus.buf_wen   <= 1'b1;
              bus.buf_waddr <= bus.cmd_addr;
              bus.buf_wdata <= bus.cmd_char;
              bus.done      <= 1'b1;
              state         <= S_PUTC;
            end
            OP_CLR_SCREEN: begin
              bus.buf_wen   <= 1'b1;
              bus.buf_waddr <= '0;
              bus.buf_wdata <= BLANK;
              end_addr      <= LAST_ADDR;
              state         <= S_CLEAR;
            end
            OP_CLR_EOL: begin
              bus.buf_wen   <= 1'b1;
              bus.buf_waddr <= bus.cmd_addr;
              bus.buf_wdata <= BLANK;
              end_addr      <= bus.cmd_addr | COL_MASK;
              bus.done      <= (bus.cmd_addr & COL_MASK) == COL_MASK;
              state         <= S_CLEAR;
            end
            default: begin
              bus.buf_raddr <= ADDR_W'(COLS);
              end_addr      <= LAST_ADDR;
              state         <= S_COPY;
            end
          endcase
        end
        S_PUTC: begin
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end
        // FILL starts from the last copy write (959) and steps to the last row.
        S_CLEAR, S_FILL: begin
          if (bus.buf_waddr == end_addr) begin
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= S_IDLE;
          end else begin
            bus.buf_wen   <= 1'b1;
            bus.buf_waddr <= waddr_nxt;
            bus.buf_wdata <= BLANK;
            bus.done      <= waddr_nxt == end_addr;
          end
        end
        S_COPY: begin
          bus.buf_wen   <= 1'b1;
          bus.buf_waddr <= bus.buf_raddr - ADDR_W'(COLS);
          bus.buf_wdata <= bus.buf_rdata;
          if (bus.buf_raddr == end_addr) state <= S_FILL;
          else bus.buf_raddr <= bus.buf_raddr + ADDR_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_screen_write_sequencer.sv
// Directed bench: a queue of per-cycle expected buffer activity, built from each accepted command.
module tb_screen_write_sequencer;
  import term_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  screen_write_sequencer_if bus();
  screen_write_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  logic [7:0] mem [0:1023];
  logic       preload = 1'b0;
  assign bus.buf_rdata = mem[bus.buf_raddr];

  always @(posedge clk) begin
    if (preload) for (int a = 0; a < 1024; a++) mem[a] <= 8'(a);
    else if (bus.buf_wen) mem[bus.buf_waddr] <= bus.buf_wdata;
  end

  typedef struct {
    logic       wen;
    logic [9:0] waddr;
    logic [7:0] wdata;
    logic       done;
    logic       chk_r;
    logic [9:0] raddr;
  } exp_t;

  exp_t exp_q[$];
  logic exp_ready = 1'b1;
  logic started   = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input int wen, input int wa, input int wd, input int dn,
                              input int cr, input int ra);
    exp_t e;
    e.wen = 1'(wen); e.waddr = 10'(wa); e.wdata = 8'(wd);
    e.done = 1'(dn); e.chk_r = 1'(cr); e.raddr = 10'(ra);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  // Expected activity per cycle after an accepted command, from the command's meaning.
  task automatic model_loop();
    int row_end;
    forever begin
      @(posedge clk);
      started = 1'b1;
      if (!clr) exp_q.delete();
      else if (bus.cmd_valid && exp_ready) begin
        case (bus.cmd_op)
          OP_PUTC: exp_q.push_back(mk(1, int'(bus.cmd_addr), int'(bus.cmd_char), 1, 0, 0));
          OP_CLR_SCREEN:
            for (int a = 0; a < 1024; a++) exp_q.push_back(mk(1, a, 32, a == 1023, 0, 0));
          OP_CLR_EOL: begin
            row_end = int'(bus.cmd_addr) | 63;
            for (int a = int'(bus.cmd_addr); a <= row_end; a++)
              exp_q.push_back(mk(1, a, 32, a == row_end, 0, 0));
          end
          default: begin
            exp_q.push_back(mk(0, 0, 0, 0, 1, 64));
            for (int k = 0; k < 960; k++)
              exp_q.push_back(mk(1, k, int'(mem[k+64]), 0, k < 959, k + 65));
            for (int a = 960; a < 1024; a++) exp_q.push_back(mk(1, a, 32, a == 1023, 0, 0));
          end
        endcase
      end
    end
  endtask

  task automatic compare_loop();
    exp_t e;
    logic r;
    logic [31:0] got, want;
    forever begin
      @(negedge clk);
      if (started) begin
        r = (exp_q.size() == 0);
        exp_ready = r;
        if (!r) e = exp_q.pop_front();
        else e = mk(0, 0, 0, 0, 0, 0);
        got  = {4'h0, bus.buf_wen, bus.done, bus.cmd_ready, bus.busy,
                e.wen ? bus.buf_waddr : 10'd0, e.wen ? bus.buf_wdata : 8'd0,
                e.chk_r ? bus.buf_raddr : 10'd0};
        want = {4'h0, e.wen, e.done, r, !r, e.waddr, e.wdata, e.chk_r ? e.raddr : 10'd0};
        chk("cycle{wen,done,rdy,busy|waddr|wdata|raddr}", got, want);
      end
    end
  endtask

  task automatic issue(input op_e op, input logic [7:0] ch, input logic [9:0] ad, output int lo);
    bus.cmd_op = op; bus.cmd_char = ch; bus.cmd_addr = ad; bus.cmd_valid = 1'b1;
    lo = 0;
    @(negedge clk);
    while (!bus.cmd_ready && lo < 3000) begin lo++; @(negedge clk); end
    chk("accept_timeout", 32'(lo >= 3000), 0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.done && cyc < 3000);
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload();
    @(negedge clk); preload = 1'b1;
    @(posedge clk); #1 preload = 1'b0;
  endtask

  initial begin
    int lo, cyc, n;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_PUTC; bus.cmd_char = 8'h00; bus.cmd_addr = '0;
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_waddr", 32'(bus.buf_waddr), 0);
    chk("rst_raddr", 32'(bus.buf_raddr), 0);
    chk("rst_wdata", 32'(bus.buf_wdata), 0);
    clr = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);

    // Abort a screen clear at address 300.
    do_preload();
    issue(OP_CLR_SCREEN, 8'h00, 10'h000, lo);
    n = 0;
    while (!(bus.buf_wen && bus.buf_waddr == 10'd300) && n < 2000) begin @(negedge clk); n++; end
    chk("abort_wait_timeout", 32'(n >= 2000), 0);
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_m299", 32'(mem[299]), 32'h20);
    chk("abort_m300", 32'(mem[300]), 32'h20);
    chk("abort_m301", 32'(mem[301]), 32'h2D);
    chk("abort_m500", 32'(mem[500]), 32'hF4);

    // PUTC then a back-to-back PUTC.
    issue(OP_PUTC, 8'h41, 10'h045, lo);
    issue(OP_PUTC, 8'h42, 10'h046, lo);
    chk("b2b_wait", 32'(lo), 1);
    wait_done(cyc);
    chk("putc_done_cyc", 32'(cyc), 1);
    chk("putc_m45", 32'(mem[10'h045]), 32'h41);
    chk("putc_m46", 32'(mem[10'h046]), 32'h42);

    // Clear to end of line, mid-row and at the last column.
    do_preload();
    issue(OP_CLR_EOL, 8'h00, 10'h0FC, lo);
    wait_done(cyc);
    chk("eol_done_cyc", 32'(cyc), 4);
    chk("eol_mFB", 32'(mem[10'h0FB]), 32'hFB);
    chk("eol_mFF", 32'(mem[10'h0FF]), 32'h20);
    chk("eol_m100", 32'(mem[10'h100]), 32'h00);
    issue(OP_CLR_EOL, 8'h00, 10'h13F, lo);
    wait_done(cyc);
    chk("eol63_done_cyc", 32'(cyc), 1);
    chk("eol63_m13E", 32'(mem[10'h13E]), 32'h3E);
    chk("eol63_m13F", 32'(mem[10'h13F]), 32'h20);

    // Full clear.
    issue(OP_CLR_SCREEN, 8'h00, 10'h000, lo);
    wait_done(cyc);
    chk("clr_done_cyc", 32'(cyc), 1024);
    chk("clr_m777", 32'(mem[777]), 32'h20);

    // Scroll a preloaded screen.
    do_preload();
    issue(OP_SCROLL, 8'h00, 10'h000, lo);
    wait_done(cyc);
    chk("scroll_done_cyc", 32'(cyc), 1025);
    chk("scroll_m0", 32'(mem[0]), 32'h40);
    chk("scroll_m500", 32'(mem[500]), 32'h34);
    chk("scroll_m959", 32'(mem[959]), 32'hFF);
    chk("scroll_m960", 32'(mem[960]), 32'h20);
    chk("scroll_m1023", 32'(mem[1023]), 32'h20);

    // Hold valid through a scroll, switching op before acceptance.
    issue(OP_SCROLL, 8'h00, 10'h000, lo);
    bus.cmd_op = OP_CLR_SCREEN; bus.cmd_valid = 1'b1;
    repeat (100) @(negedge clk);
    issue(OP_PUTC, 8'h5A, 10'h3FF, lo);
    chk("hold_wait", 32'(lo), 925);
    wait_done(cyc);
    chk("hold_putc_cyc", 32'(cyc), 1);
    chk("hold_m3FF", 32'(mem[10'h3FF]), 32'h5A);
    chk("hold_m0", 32'(mem[0]), 32'h80);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/screen_write_sequencer.md
Name: screen_write_sequencer

Overview:
Sole owner of the char buffer write port; sequences screen-editing commands from the keyboard/terminal front end into buffer writes. It executes single-char put, clear screen, clear to end of line and scroll up (read/copy/blank-fill). The front end issues one command per valid/ready handshake and tracks the cursor itself. Sits between the PS/2 decode logic and char_generator's write port in the px_clk domain.

Parameters:
COLS, 64, characters per row (power of 2)
ROWS, 16, rows per screen (power of 2)
ADDR_W, 10, buffer address width = log2(COLS*ROWS)
BLANK, 8'h20, fill character for clears and scroll

Ports:
clk  in  1  pixel clock
clr  in  1  reset: synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  2  0=PUTC, 1=CLR_SCREEN, 2=CLR_EOL, 3=SCROLL_UP
cmd_char  in  8  character for PUTC
cmd_addr  in  ADDR_W  {row,col} target for PUTC and CLR_EOL
buf_waddr  out  ADDR_W  char buffer write address
buf_wdata  out  8  char buffer write data
buf_wen  out  1  char buffer write enable
buf_raddr  out  ADDR_W  char buffer read address (scroll)
buf_rdata  in  8  read data, valid 1 cycle after buf_raddr
busy  out  1  command in progress (= !cmd_ready)
done  out  1  1-cycle pulse coincident with last write of a command

Behaviour:
- All outputs registered. Reset (clr=0 at posedge): state IDLE, cmd_ready=1 on the first cycle after reset deasserts, buf_wen=0, done=0, busy=0, buf_waddr=buf_raddr=0, buf_wdata=0.
- Reset mid-command aborts immediately; no further writes; partial buffer contents are left as-is.
- Accept: cmd_valid & cmd_ready at posedge; cmd_op/char/addr captured. cmd_ready=0 from the next cycle until the cycle after done. Back-to-back: a new command can be accepted in the first cycle cmd_ready is back high.
- States: IDLE, PUTC, CLEAR, COPY, FILL.
- PUTC: one write of cmd_char to cmd_addr in the cycle after accept; done in the same cycle; then IDLE.
- CLR_SCREEN: CLEAR state; writes BLANK to addresses 0..COLS*ROWS-1 on consecutive cycles starting the cycle after accept (1024 writes); done on addr 1023.
- CLR_EOL: CLEAR state from cmd_addr to (cmd_addr | COLS-1) inclusive; col 63 gives one write.
- SCROLL_UP, COPY state (pipelined):
  - buf_raddr steps COLS..COLS*ROWS-1, one per cycle, starting cycle 1 after accept.
  - Each returned byte is written to raddr-COLS one cycle later: waddr 0..959 on cycles 2..961.
- SCROLL_UP, FILL state: BLANK written to the last row, 960..1023, on cycles 962..1025; done at 1025; no gap between COPY and FILL.
- Counter: ADDR_W-bit pointer; termination by explicit compare, never by wrap; COLS-1 masking for end-of-row.
- buf_wen is never high in IDLE; exactly one write per cycle maximum.
- cmd_op, cmd_char and cmd_addr are ignored when not accepted. cmd_valid is held while cmd_ready=0 without side effects.

Decomposition:
- Shared package (term_pkg): op encodings (OP_PUTC, OP_CLR_SCREEN, OP_CLR_EOL, OP_SCROLL); COLS, ROWS, ADDR_W, BLANK constants. PS/2 decode and top reuse these.
- Single module; no sub-module needed. The pointer/compare logic stays inline.

Test Plan:
- Reset (clr=0, 2 cycles) → next cycle cmd_ready=1, buf_wen=0, done=0. Assert clr=0 during CLR_SCREEN at addr 300 → no writes after reset; cmd_ready=1 after release.
- PUTC char 8'h41 at addr 10'h045 → one cycle later buf_wen=1, waddr=0x045, wdata=0x41, done=1. cmd_ready returns next cycle; back-to-back PUTC accepted then.
- CLR_EOL at addr {row 3, col 60}=0x0FC → 4 writes, BLANK to 0x0FC..0x0FF, done on 0x0FF. CLR_EOL at col 63 → single write.
- CLR_SCREEN → 1024 consecutive writes 0..1023 of 0x20, done on 1023, busy high throughout.
- SCROLL_UP on a buffer model preloaded with mem[a]=a[7:0] → mem[a]=(a+64)[7:0] for a<960, mem[960..1023]=0x20, done at cycle 1025 after accept.
- Hold cmd_valid with a different op during SCROLL → not accepted until cmd_ready; captured op is the value present on the accepting edge.
